sdram_port_sched: RTL and testbench

- Single-port SDRAM scheduler for the Oric core.
- Shares one toggle-handshake SDRAM port between three requesters:
  - ROM/TAP download writes from data_io.
  - CPU RAM/ROM byte accesses.
  - TAP-player byte fetches.
- Arbitration is fixed priority (download > CPU > tape) with anti-starvation aging for the tape.
- Sits between the Oric/tap_player/data_io byte interfaces and the sdram controller port.

---
 rtl/sdram_port_sched.sv | 209 ++++++++++++++++++++
 tb/tb_sdram_port_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_sched.sv
// rtl/sdram_port_sched.sv - single toggle-handshake SDRAM port shared by download, CPU and tape requesters
// Fixed priority download > CPU > tape, with tape aging that lifts it above the CPU once starved.
module sdram_port_sched #(
    parameter int STARVE_LIMIT = 64,
    parameter int AW           = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_overrun,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_done,
    input  logic          tap_req,
    output logic          tap_ack,
    input  logic [AW-1:0] tap_addr,
    input  logic [AW-1:0] tap_last,
    output logic [7:0]    tap_data,
    output logic          mem_req,
    input  logic          mem_ack,
    output logic [AW-2:0] mem_a,
    output logic [1:0]    mem_ds,
    output logic          mem_we,
    output logic [15:0]   mem_d,
    input  logic [15:0]   mem_q
);

    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_RESYNC, S_IDLE, S_WAIT} state_t;
    typedef enum logic [1:0] {OWN_DL, OWN_CPU, OWN_TAP} owner_t;

    state_t state, next_state;
    owner_t owner;

    logic          dl_pend, dl_wr_d;
    logic [AW-1:0] dl_addr_q;
    logic [7:0]    dl_data_q;
    logic          cpu_pend, cpu_we_q;
    logic [AW-1:0] cpu_addr_q;
    logic [7:0]    cpu_din_q;
    logic [AGE_W-1:0] age;
    logic          cur_addr0;

    logic          tap_pend, tap_blocked, tap_starved, tap_oor, mem_idle;
    logic          grant_dl, grant_cpu, grant_tap, issue, complete;
    logic [AW-1:0] iss_addr;
    logic [7:0]    iss_byte;
    logic          iss_we;
    logic [7:0]    rd_byte;

    assign tap_pend    = (tap_req != tap_ack);
    // Tape stays off the bus while a download is queued or just strobed.
    assign tap_blocked = dl_pend | dl_wr | dl_wr_d;
    assign tap_starved = (age == AGE_MAX);
    assign tap_oor     = (tap_addr > tap_last);
    assign mem_idle    = (mem_req == mem_ack);
    assign rd_byte     = cur_addr0 ? mem_q[15:8] : mem_q[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RESYNC;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant_dl   = 1'b0;
        grant_cpu  = 1'b0;
        grant_tap  = 1'b0;
        complete   = 1'b0;
        case (state)
            S_RESYNC: next_state = S_IDLE;
            S_IDLE: begin
                if (mem_idle) begin
                    if (dl_pend)
                        grant_dl = 1'b1;
                    else if (tap_pend && !tap_blocked && tap_starved)
                        grant_tap = 1'b1;
                    else if (cpu_pend)
                        grant_cpu = 1'b1;
                    else if (tap_pend && !tap_blocked)
                        grant_tap = 1'b1;
                end
                if (grant_dl || grant_cpu || (grant_tap && !tap_oor))
                    next_state = S_WAIT;
            end
            S_WAIT: begin
                if (mem_idle) begin
                    complete   = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_RESYNC;
        endcase
    end

    assign issue = grant_dl | grant_cpu | (grant_tap & ~tap_oor);

    always_comb begin
        iss_addr = tap_addr;
        iss_byte = 8'h00;
        iss_we   = 1'b0;
        if (grant_dl) begin
            iss_addr = dl_addr_q;
            iss_byte = dl_data_q;
            iss_we   = 1'b1;
        end else if (grant_cpu) begin
            iss_addr = cpu_addr_q;
            iss_byte = cpu_din_q;
            iss_we   = cpu_we_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_pend    <= 1'b0;
            dl_wr_d    <= 1'b0;
            dl_addr_q  <= '0;
            dl_data_q  <= '0;
            dl_overrun <= 1'b0;
            cpu_pend   <= 1'b0;
            cpu_we_q   <= 1'b0;
            cpu_addr_q <= '0;
            cpu_din_q  <= '0;
            cpu_dout   <= '0;
            cpu_done   <= 1'b0;
            tap_ack    <= 1'b0;
            tap_data   <= '0;
            age        <= '0;
            owner      <= OWN_DL;
            cur_addr0  <= 1'b0;
            mem_req    <= 1'b0;
            mem_a      <= '0;
            mem_ds     <= '0;
            mem_we     <= 1'b0;
            mem_d      <= '0;
        end else begin
            dl_wr_d  <= dl_wr;
            cpu_done <= 1'b0;

            // A strobe in the grant cycle re-arms the flag the grant clears.
            if (dl_wr) begin
                dl_pend   <= 1'b1;
                dl_addr_q <= dl_addr;
                dl_data_q <= dl_data;
                if (dl_pend)
                    dl_overrun <= 1'b1;
            end else if (grant_dl) begin
                dl_pend <= 1'b0;
            end

            if (cpu_rd || cpu_wr) begin
                cpu_pend   <= 1'b1;
                cpu_addr_q <= cpu_addr;
                cpu_din_q  <= cpu_din;
                cpu_we_q   <= cpu_wr;
            end else if (grant_cpu) begin
                cpu_pend <= 1'b0;
            end

            if (!tap_pend || grant_tap)
                age <= '0;
            else if (age != AGE_MAX)
                age <= age + AGE_W'(1);

            if (state == S_RESYNC)
                mem_req <= mem_ack;

            if (issue) begin
                mem_a     <= iss_addr[AW-1:1];
                mem_ds    <= iss_we ? (iss_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                mem_d     <= {iss_byte, iss_byte};
                mem_we    <= iss_we;
                mem_req   <= ~mem_req;
                cur_addr0 <= iss_addr[0];
                owner     <= grant_dl ? OWN_DL : (grant_cpu ? OWN_CPU : OWN_TAP);
            end

            if (grant_tap && tap_oor) begin
                tap_data <= 8'h00;
                tap_ack  <= tap_req;
            end

            if (complete) begin
                case (owner)
                    OWN_CPU: begin
                        cpu_dout <= rd_byte;
                        cpu_done <= 1'b1;
                    end
                    OWN_TAP: begin
                        tap_data <= rd_byte;
                        tap_ack  <= ~tap_ack;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_sched.sv
// tb/tb_sdram_port_sched.sv - directed plus randomized bench for sdram_port_sched against a byte-memory model
module tb_sdram_port_sched;
    localparam int AW = 24;
    localparam int SL = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dl_wr = 1'b0;
    logic [AW-1:0] dl_addr = '0;
    logic [7:0]    dl_data = '0;
    logic          dl_overrun;
    logic          cpu_rd = 1'b0;
    logic          cpu_wr = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_din = '0;
    logic [7:0]    cpu_dout;
    logic          cpu_done;
    logic          tap_req = 1'b0;
    logic          tap_ack;
    logic [AW-1:0] tap_addr = '0;
    logic [AW-1:0] tap_last = '0;
    logic [7:0]    tap_data;
    logic          mem_req;
    logic          mem_ack = 1'b0;
    logic [AW-2:0] mem_a;
    logic [1:0]    mem_ds;
    logic          mem_we;
    logic [15:0]   mem_d;
    logic [15:0]   mem_q = '0;

    always #5 clk = ~clk;

    sdram_port_sched #(.STARVE_LIMIT(SL), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_overrun(dl_overrun),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_done(cpu_done),
        .tap_req(tap_req), .tap_ack(tap_ack), .tap_addr(tap_addr), .tap_last(tap_last),
        .tap_data(tap_data),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_a(mem_a), .mem_ds(mem_ds),
        .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q)
    );

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [AW-2:0] a;
        logic [1:0]    ds;
        logic          we;
        logic [15:0]   d;
    } rec_t;

    logic [15:0] sdram [0:4095];
    logic [7:0]  refm  [0:8191];
    rec_t        recs[$];
    int          lat = 5;
    int          cnt = 0;
    logic        prev_req = 1'b0;

    // SDRAM controller model: acks a toggle after lat cycles, logs every issued command.
    always @(negedge clk) begin
        if (reset) begin
            cnt = 0;
            prev_req = mem_req;
        end else begin
            if (mem_req != prev_req) begin
                recs.push_back({mem_a, mem_ds, mem_we, mem_d});
                prev_req = mem_req;
            end
            if (mem_req != mem_ack) begin
                cnt++;
                if (cnt >= lat) begin
                    if (mem_we) begin
                        if (mem_ds[0]) sdram[mem_a[11:0]][7:0]  = mem_d[7:0];
                        if (mem_ds[1]) sdram[mem_a[11:0]][15:8] = mem_d[15:8];
                    end else begin
                        mem_q = sdram[mem_a[11:0]];
                    end
                    mem_ack = mem_req;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [7:0] d, input string tag);
        int n = 0;
        cpu_addr = a; cpu_din = d; cpu_wr = we; cpu_rd = !we;
        @(negedge clk);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        while (cpu_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, cpu_done, 1);
        if (we) refm[a[12:0]] = d;
        else chk({tag, "_rd"}, cpu_dout, refm[a[12:0]]);
        @(negedge clk);
        chk({tag, "_pulse"}, cpu_done, 0);
    endtask

    task automatic tap_op(input logic [AW-1:0] a, input logic [AW-1:0] last, input int maxc,
                          input string tag, output int n);
        logic [7:0] exp_b;
        exp_b = (a > last) ? 8'h00 : refm[a[12:0]];
        tap_addr = a; tap_last = last; tap_req = ~tap_req; n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tap_ack !== tap_req && n < maxc);
        chk({tag, "_ack"}, tap_ack, tap_req);
        chk({tag, "_data"}, tap_data, exp_b);
    endtask

    task automatic dl_write(input logic [AW-1:0] a, input logic [7:0] d);
        dl_addr = a; dl_data = d; dl_wr = 1'b1;
        @(negedge clk);
        dl_wr = 1'b0;
        refm[a[12:0]] = d;
    endtask

    logic [7:0]    dlb [4];
    logic [AW-1:0] ra, rl;
    logic [7:0]    rb;
    int            op, n, nrec;
    logic          done_seen;
    rec_t          r;

    initial begin
        for (int w = 0; w < 4096; w++) begin
            refm[2*w]   = 8'($urandom);
            refm[2*w+1] = 8'($urandom);
            sdram[w]    = {refm[2*w+1], refm[2*w]};
        end
        sdram[1] = 16'hA55A; refm[2] = 8'h5A; refm[3] = 8'hA5;
        dlb[0] = 8'h11; dlb[1] = 8'h22; dlb[2] = 8'h33; dlb[3] = 8'h44;

        repeat (3) @(negedge clk);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_d", mem_d, 0);
        chk("rst_misc", {dl_overrun, cpu_dout, cpu_done, tap_ack, tap_data, mem_req, mem_ds, mem_we}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // CPU read of 0x1_0003 against a 5-cycle controller
        recs.delete(); lat = 5;
        cpu_op(1'b0, 24'h01_0003, 8'h00, "t1");
        r = (recs.size() > 0) ? recs[0] : '0;
        chk("t1_nreq", recs.size(), 1);
        chk("t1_mem_a", r.a, 23'h8001);
        chk("t1_mem_ds", r.ds, 2'b11);
        chk("t1_mem_we", r.we, 0);
        chk("t1_dout", cpu_dout, 8'hA5);

        tap_op(24'h3, 24'hFF, 20, "tap_in", n);
        recs.delete();
        tap_op(24'h100, 24'h0FF, 2, "tap_oor", n);
        repeat (3) @(negedge clk);
        chk("tap_oor_noreq", recs.size(), 0);

        // Four spaced download writes
        recs.delete();
        for (int i = 0; i < 4; i++) begin
            dl_write(AW'(i), dlb[i]);
            repeat (7) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("dl_nreq", recs.size(), 4);
        nrec = recs.size();
        for (int i = 0; i < 4 && i < nrec; i++) begin
            chk($sformatf("dl%0d_ds", i), recs[i].ds, (i % 2) ? 2'b10 : 2'b01);
            chk($sformatf("dl%0d_d", i), recs[i].d, {dlb[i], dlb[i]});
            chk($sformatf("dl%0d_a", i), {recs[i].a, recs[i].we}, {23'(i / 2), 1'b1});
        end
        chk("dl_no_overrun", dl_overrun, 0);

        // Back-to-back download strobes against a stalled controller
        recs.delete(); lat = 20;
        dl_addr = 24'h10; dl_data = 8'hAA; dl_wr = 1'b1;
        @(negedge clk);
        dl_addr = 24'h11; dl_data = 8'hBB;
        @(negedge clk);
        dl_wr = 1'b0;
        refm[16] = 8'hAA; refm[17] = 8'hBB;
        repeat (60) @(negedge clk);
        chk("b2b_overrun", dl_overrun, 1);
        chk("b2b_nreq", recs.size(), 2);
        chk("b2b_second", sdram[8][15:8], 8'hBB);
        chk("b2b_first", sdram[8][7:0], 8'hAA);

        // Randomized traffic against the byte-memory reference
        for (int it = 0; it < 40; it++) begin
            lat = $urandom_range(1, 6);
            op  = $urandom_range(0, 3);
            ra  = AW'($urandom);
            rb  = 8'($urandom);
            case (op)
                0: cpu_op(1'b1, ra, rb, $sformatf("rnd%0d_wr", it));
                1: cpu_op(1'b0, ra, rb, $sformatf("rnd%0d_rd", it));
                2: begin
                    rl = ($urandom_range(0, 1) != 0) ? ra + AW'($urandom_range(0, 3)) : ra - AW'(1);
                    tap_op(ra, rl, 3 * lat + 12, $sformatf("rnd%0d_tap", it), n);
                end
                default: begin
                    dl_write(ra, rb);
                    repeat (lat + 8) @(negedge clk);
                end
            endcase
            @(negedge clk);
        end

        // Continuous CPU demand: tape must get through by aging, not before
        lat = 4;
        cpu_addr = AW'($urandom); cpu_rd = 1'b1;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tap_op(AW'($urandom), {AW{1'b1}}, SL + 3 * (lat + 4), $sformatf("starve%0d", k), n);
            chk($sformatf("starve%0d_min", k), n >= SL, 1);
            repeat (3) @(negedge clk);
        end
        cpu_rd = 1'b0;
        repeat (20) @(negedge clk);

        // Reset in the middle of a CPU read
        lat = 10; done_seen = 1'b0;
        cpu_addr = 24'h3; cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            done_seen = done_seen | cpu_done;
        end
        reset = 1'b0;
        @(negedge clk);
        chk("rst_resync", mem_req, mem_ack);
        repeat (20) begin
            @(negedge clk);
            done_seen = done_seen | cpu_done;
        end
        chk("rst_no_done", done_seen, 0);
        chk("rst_overrun_clr", dl_overrun, 0);
        lat = 3;
        cpu_op(1'b0, 24'h01_0003, 8'h00, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
